fft_config_rx: RTL and testbench
================================

FFT_CONFIG_RX -- requirements
Module: fft_config_rx

Interface
REQ-001 SHALL have parameter SCALE_W, default 8, scale-schedule field width.
REQ-002 SHALL have parameter DEF_SCALE, default 8'h00, active scale schedule after reset.
REQ-003 SHALL have parameter DEF_FWD, default 1, active direction after reset (1 = forward).
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port s_cfg_tvalid  input  1  config word valid.
REQ-007 SHALL have port s_cfg_tready  output  1  config word accepted when high with tvalid.
REQ-008 SHALL have port s_cfg_tlast  input  1  end-of-packet marker, expected high on every word.
REQ-009 SHALL have port s_cfg_tdata  input  16  config word: bit0 = fwd, bits[SCALE_W:1] = scale, remaining bits reserved zero.
REQ-010 SHALL have port frame_start  input  1  single-cycle pulse, datapath begins a frame.
REQ-011 SHALL have port frame_done  input  1  single-cycle pulse, datapath ends a frame.
REQ-012 SHALL have port cfg_fwd  output  1  active direction.
REQ-013 SHALL have port cfg_scale_sch  output  SCALE_W  active scale schedule.
REQ-014 SHALL have port cfg_pending  output  1  staged word awaiting application.
REQ-015 SHALL have port cfg_apply  output  1  one-cycle pulse, active config updated this cycle.
REQ-016 SHALL have port ev_tlast_missing  output  1  one-cycle pulse, word accepted with tlast low.
REQ-017 SHALL have port ev_reserved  output  1  one-cycle pulse, word accepted with nonzero reserved bits.

Function
REQ-018 SHALL implement states IDLE (s_cfg_tready=1) and PENDING (s_cfg_tready=0); all outputs registered.
REQ-019 SHALL, in IDLE on tvalid&&tready, capture fwd and scale into staged register, drop tready and enter PENDING at the same edge.
REQ-020 SHALL keep a busy flag: set on frame_start, cleared on frame_done; both in one cycle leaves busy=1.
REQ-021 SHALL, in PENDING, apply when busy==0 or frame_done==1: active <= staged, cfg_apply=1 for one cycle, enter IDLE, tready=1 next cycle.
REQ-022 SHALL, when frame_done and frame_start coincide with an apply, make the new frame use the new config.
REQ-023 SHALL, when frame_start and apply occur in the same cycle with busy==0, apply the new config before that frame.
REQ-024 SHALL never change cfg_fwd/cfg_scale_sch while busy==1 except on a frame_done cycle.
REQ-025 SHALL accept a word with tlast low and pulse ev_tlast_missing the cycle after handshake.
REQ-026 SHALL accept a word with nonzero reserved bits, ignore those bits, pulse ev_reserved the cycle after handshake.
REQ-027 SHALL drive cfg_pending=1 exactly while in PENDING.
REQ-028 SHALL accept at most one word per apply; a second word waits with tvalid held high.

Reset
REQ-029 SHALL, while resetn low at a clock edge: tready=0, state IDLE, busy=0, cfg_pending=0, all pulses 0, cfg_fwd=DEF_FWD, cfg_scale_sch=DEF_SCALE.
REQ-030 SHALL discard any staged word on reset mid-PENDING; no apply.
REQ-031 SHALL raise s_cfg_tready at the first edge with resetn high.

Structure
REQ-032 SHALL place field offsets (FWD_BIT=0, SCALE_LSB=1), reserved-mask function and state encoding in shared package fft_config_pkg.
REQ-033 SHALL use one sub-module fft_config_field_decode (combinational word-to-fields plus reserved-error flag).

Verification
REQ-034 Reset release, word 16'h0155 tlast=1, busy=0 -> accepted, cfg_apply one cycle later, cfg_fwd=1, cfg_scale_sch=8'hAA, no events.
REQ-035 frame_start, then word 16'h0002 -> cfg_pending=1, tready=0, outputs unchanged until frame_done, then cfg_fwd=0, cfg_scale_sch=8'h01.
REQ-036 Word 16'h8003 tlast=0 -> accepted, ev_tlast_missing and ev_reserved each pulse once, cfg_scale_sch=8'h01, cfg_fwd=1.
REQ-037 Busy, word staged, frame_done and frame_start same cycle -> cfg_apply that edge, busy stays 1, new frame sees new config.
REQ-038 Word staged while busy, resetn low one cycle -> defaults restored, cfg_pending=0, no cfg_apply, tready=1 after release.
REQ-039 Two back-to-back words with tvalid held -> second accepted only after first applied; tready low between.

Source files
------------

// File: rtl/fft_config_pkg.sv
// Shared definitions for the FFT configuration receiver.
// Holds config-word field offsets, the reserved-bit mask helper and the
// receiver state encoding.
package fft_config_pkg;

  localparam int unsigned CFG_W     = 16;
  localparam int unsigned FWD_BIT   = 0;
  localparam int unsigned SCALE_LSB = 1;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  // Every bit above the fwd bit and the scale field is reserved.
  function automatic logic [CFG_W-1:0] reserved_mask(input int unsigned scale_w);
    logic [CFG_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < CFG_W; i++) begin
      if (i > scale_w) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/fft_config_field_decode.sv
// Combinational split of a config word into its fields.
// Ports:
//   word         in  16-bit config word
//   fwd          out direction bit (1 = forward)
//   scale        out SCALE_W-bit scale schedule
//   reserved_err out high when any reserved bit is set
module fft_config_field_decode
  import fft_config_pkg::*;
#(
  parameter int unsigned SCALE_W = 8
) (
  input  logic [CFG_W-1:0]   word,
  output logic               fwd,
  output logic [SCALE_W-1:0] scale,
  output logic               reserved_err
);

  localparam logic [CFG_W-1:0] RSV_MASK = reserved_mask(SCALE_W);

  always_comb begin
    fwd          = word[FWD_BIT];
    scale        = word[SCALE_LSB +: SCALE_W];
    reserved_err = |(word & RSV_MASK);
  end

endmodule

// File: rtl/fft_config_rx.sv
// FFT configuration receiver: accepts one config word over a stream
// interface, stages it, and applies it to the active configuration only
// between frames (or on the frame_done edge). All outputs are registered.
// Ports:
//   clk, resetn               clock, synchronous active-low reset
//   s_cfg_tvalid/tready/tlast config stream handshake and end marker
//   s_cfg_tdata               config word (bit0 fwd, scale above it)
//   frame_start, frame_done   datapath frame boundary pulses
//   cfg_fwd, cfg_scale_sch    active configuration
//   cfg_pending               a staged word awaits application
//   cfg_apply                 pulse: active config updated this cycle
//   ev_tlast_missing          pulse: accepted word had tlast low
//   ev_reserved               pulse: accepted word had reserved bits set
module fft_config_rx
  import fft_config_pkg::*;
#(
  parameter int unsigned         SCALE_W   = 8,
  parameter logic [SCALE_W-1:0]  DEF_SCALE = 8'h00,
  parameter logic                DEF_FWD   = 1'b1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               s_cfg_tvalid,
  output logic               s_cfg_tready,
  input  logic               s_cfg_tlast,
  input  logic [15:0]        s_cfg_tdata,
  input  logic               frame_start,
  input  logic               frame_done,
  output logic               cfg_fwd,
  output logic [SCALE_W-1:0] cfg_scale_sch,
  output logic               cfg_pending,
  output logic               cfg_apply,
  output logic               ev_tlast_missing,
  output logic               ev_reserved
);

  logic [0:0]         state;
  logic               busy;
  logic               staged_fwd;
  logic [SCALE_W-1:0] staged_scale;

  logic               dec_fwd;
  logic [SCALE_W-1:0] dec_scale;
  logic               dec_rsv;
  logic               handshake;
  logic               apply_now;

  fft_config_field_decode #(
    .SCALE_W(SCALE_W)
  ) u_decode (
    .word        (s_cfg_tdata),
    .fwd         (dec_fwd),
    .scale       (dec_scale),
    .reserved_err(dec_rsv)
  );

  assign handshake = (state == ST_IDLE) && s_cfg_tvalid && s_cfg_tready;
  // frame_done lets the apply land on the boundary even if a new frame
  // starts in the same cycle, so that frame picks up the new config.
  assign apply_now = (state == ST_PENDING) && (!busy || frame_done);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state            <= ST_IDLE;
      busy             <= 1'b0;
      s_cfg_tready     <= 1'b0;
      staged_fwd       <= DEF_FWD;
      staged_scale     <= DEF_SCALE;
      cfg_fwd          <= DEF_FWD;
      cfg_scale_sch    <= DEF_SCALE;
      cfg_pending      <= 1'b0;
      cfg_apply        <= 1'b0;
      ev_tlast_missing <= 1'b0;
      ev_reserved      <= 1'b0;
    end else begin
      cfg_apply        <= 1'b0;
      ev_tlast_missing <= 1'b0;
      ev_reserved      <= 1'b0;

      if (state == ST_IDLE) begin
        s_cfg_tready <= 1'b1;
        if (handshake) begin
          staged_fwd       <= dec_fwd;
          staged_scale     <= dec_scale;
          s_cfg_tready     <= 1'b0;
          cfg_pending      <= 1'b1;
          ev_tlast_missing <= !s_cfg_tlast;
          ev_reserved      <= dec_rsv;
          state            <= ST_PENDING;
        end
      end else if (apply_now) begin
        cfg_fwd       <= staged_fwd;
        cfg_scale_sch <= staged_scale;
        cfg_apply     <= 1'b1;
        cfg_pending   <= 1'b0;
        s_cfg_tready  <= 1'b1;
        state         <= ST_IDLE;
      end

      // start wins over done so back-to-back frames keep busy high
      if (frame_start)     busy <= 1'b1;
      else if (frame_done) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_config_rx.sv
module tb_fft_config_rx;

  logic        clk = 1'b0;
  logic        resetn;
  logic        s_cfg_tvalid;
  logic        s_cfg_tready;
  logic        s_cfg_tlast;
  logic [15:0] s_cfg_tdata;
  logic        frame_start;
  logic        frame_done;
  logic        cfg_fwd;
  logic [7:0]  cfg_scale_sch;
  logic        cfg_pending;
  logic        cfg_apply;
  logic        ev_tlast_missing;
  logic        ev_reserved;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned n_apply = 0;
  int unsigned n_evt   = 0;
  int unsigned n_evr   = 0;

  fft_config_rx #(
    .SCALE_W  (8),
    .DEF_SCALE(8'h00),
    .DEF_FWD  (1'b1)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .s_cfg_tvalid    (s_cfg_tvalid),
    .s_cfg_tready    (s_cfg_tready),
    .s_cfg_tlast     (s_cfg_tlast),
    .s_cfg_tdata     (s_cfg_tdata),
    .frame_start     (frame_start),
    .frame_done      (frame_done),
    .cfg_fwd         (cfg_fwd),
    .cfg_scale_sch   (cfg_scale_sch),
    .cfg_pending     (cfg_pending),
    .cfg_apply       (cfg_apply),
    .ev_tlast_missing(ev_tlast_missing),
    .ev_reserved     (ev_reserved)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a word is either held for application or not;
  // the active config moves only when the held word is allowed through.
  logic       m_ready = 1'b0;
  logic       m_held  = 1'b0;
  logic       m_busy  = 1'b0;
  int         m_hold_fwd = 1;
  int         m_hold_scale = 0;
  int         m_fwd   = 1;
  int         m_scale = 0;
  logic       m_apply = 1'b0;
  logic       m_evt   = 1'b0;
  logic       m_evr   = 1'b0;

  always @(posedge clk) begin
    if (!resetn) begin
      m_ready = 1'b0; m_held = 1'b0; m_busy = 1'b0;
      m_fwd = 1; m_scale = 0;
      m_apply = 1'b0; m_evt = 1'b0; m_evr = 1'b0;
    end else begin
      m_apply = 1'b0; m_evt = 1'b0; m_evr = 1'b0;
      if (m_held && (!m_busy || frame_done)) begin
        m_fwd = m_hold_fwd; m_scale = m_hold_scale;
        m_held = 1'b0; m_apply = 1'b1; m_ready = 1'b1;
      end else if (!m_held && m_ready && s_cfg_tvalid) begin
        m_hold_fwd   = int'(s_cfg_tdata) % 2;
        m_hold_scale = (int'(s_cfg_tdata) / 2) % 256;
        m_evt        = !s_cfg_tlast;
        m_evr        = (int'(s_cfg_tdata) >= 512);
        m_held = 1'b1; m_ready = 1'b0;
      end else if (!m_held) begin
        m_ready = 1'b1;
      end
      if (frame_start)     m_busy = 1'b1;
      else if (frame_done) m_busy = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    check("tready",  32'(s_cfg_tready),     32'(m_ready));
    check("pending", 32'(cfg_pending),      32'(m_held));
    check("apply",   32'(cfg_apply),        32'(m_apply));
    check("ev_tlast",32'(ev_tlast_missing), 32'(m_evt));
    check("ev_rsv",  32'(ev_reserved),      32'(m_evr));
    check("fwd",     32'(cfg_fwd),          32'(m_fwd));
    check("scale",   32'(cfg_scale_sch),    32'(m_scale));
    if (cfg_apply === 1'b1)        n_apply++;
    if (ev_tlast_missing === 1'b1) n_evt++;
    if (ev_reserved === 1'b1)      n_evr++;
  end

  task automatic step(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_frame(input logic st, input logic dn);
    frame_start = st; frame_done = dn;
    step(1);
    frame_start = 1'b0; frame_done = 1'b0;
  endtask

  task automatic send(input logic [15:0] w, input logic last);
    int unsigned waited;
    waited = 0;
    s_cfg_tdata = w; s_cfg_tlast = last; s_cfg_tvalid = 1'b1;
    while (s_cfg_tready !== 1'b1 && waited < 50) begin
      step(1);
      waited++;
    end
    if (s_cfg_tready !== 1'b1) begin
      total++; bad++;
      $display("FAIL send_timeout: tready never rose for word %h", w);
    end
    step(1);
    s_cfg_tvalid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned a0, t0, r0;
    resetn = 1'b0; s_cfg_tvalid = 1'b0; s_cfg_tlast = 1'b1; s_cfg_tdata = '0;
    frame_start = 1'b0; frame_done = 1'b0;
    step(3);
    check("rst_fwd",     32'(cfg_fwd), 32'h1);
    check("rst_scale",   32'(cfg_scale_sch), 32'h00);
    check("rst_tready",  32'(s_cfg_tready), 32'h0);
    check("rst_pending", 32'(cfg_pending), 32'h0);
    resetn = 1'b1;
    step(1);
    check("rel_tready", 32'(s_cfg_tready), 32'h1);

    // simple apply while idle
    send(16'h0155, 1'b1);
    check("w1_pending", 32'(cfg_pending), 32'h1);
    step(1);
    check("w1_apply", 32'(cfg_apply), 32'h1);
    check("w1_fwd",   32'(cfg_fwd), 32'h1);
    check("w1_scale", 32'(cfg_scale_sch), 32'hAA);
    check("w1_events", n_evt + n_evr, 0);

    // staged while busy, applied on frame_done
    pulse_frame(1'b1, 1'b0);
    send(16'h0002, 1'b1);
    step(3);
    check("w2_hold_pend",  32'(cfg_pending), 32'h1);
    check("w2_hold_ready", 32'(s_cfg_tready), 32'h0);
    check("w2_hold_scale", 32'(cfg_scale_sch), 32'hAA);
    pulse_frame(1'b0, 1'b1);
    check("w2_apply", 32'(cfg_apply), 32'h1);
    check("w2_fwd",   32'(cfg_fwd), 32'h0);
    check("w2_scale", 32'(cfg_scale_sch), 32'h01);

    // tlast low plus reserved bit
    t0 = n_evt; r0 = n_evr;
    send(16'h8003, 1'b0);
    step(2);
    check("w3_evt_count", n_evt - t0, 1);
    check("w3_evr_count", n_evr - r0, 1);
    check("w3_fwd",   32'(cfg_fwd), 32'h1);
    check("w3_scale", 32'(cfg_scale_sch), 32'h01);

    // frame_done and frame_start together: apply, busy stays set
    pulse_frame(1'b1, 1'b0);
    send(16'h01FE, 1'b1);
    step(2);
    pulse_frame(1'b1, 1'b1);
    check("w4_apply", 32'(cfg_apply), 32'h1);
    check("w4_scale", 32'(cfg_scale_sch), 32'hFF);
    send(16'h0003, 1'b1);
    step(3);
    check("w5_still_busy", 32'(cfg_pending), 32'h1);
    pulse_frame(1'b0, 1'b1);
    check("w5_scale", 32'(cfg_scale_sch), 32'h01);

    // frame_start in the apply cycle while idle: config lands first
    send(16'h0009, 1'b1);
    pulse_frame(1'b1, 1'b0);
    check("w6_apply", 32'(cfg_apply), 32'h1);
    check("w6_scale", 32'(cfg_scale_sch), 32'h04);
    pulse_frame(1'b0, 1'b1);

    // reset while a word is staged
    pulse_frame(1'b1, 1'b0);
    send(16'h0011, 1'b1);
    step(2);
    a0 = n_apply;
    resetn = 1'b0;
    step(1);
    check("rst2_scale",   32'(cfg_scale_sch), 32'h00);
    check("rst2_pending", 32'(cfg_pending), 32'h0);
    resetn = 1'b1;
    step(1);
    check("rst2_tready", 32'(s_cfg_tready), 32'h1);
    step(3);
    check("rst2_no_apply", n_apply - a0, 0);
    check("rst2_scale_kept", 32'(cfg_scale_sch), 32'h00);

    // two words back to back with tvalid held
    pulse_frame(1'b1, 1'b0);
    s_cfg_tdata = 16'h0005; s_cfg_tlast = 1'b1; s_cfg_tvalid = 1'b1;
    step(1);
    s_cfg_tdata = 16'h0006;
    step(3);
    check("bb_ready_low", 32'(s_cfg_tready), 32'h0);
    check("bb_scale_old", 32'(cfg_scale_sch), 32'h00);
    pulse_frame(1'b0, 1'b1);
    check("bb_first_scale", 32'(cfg_scale_sch), 32'h02);
    check("bb_ready_high",  32'(s_cfg_tready), 32'h1);
    step(1);
    check("bb_second_pend", 32'(cfg_pending), 32'h1);
    s_cfg_tvalid = 1'b0;
    step(1);
    check("bb_second_fwd",   32'(cfg_fwd), 32'h0);
    check("bb_second_scale", 32'(cfg_scale_sch), 32'h03);

    step(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
